// File: rtl/sram_1024x32_arbiter_if.sv
// Bundle of both requester ports plus the SRAM wrapper pins.
// The arbiter connects to the slave side. Fabric logic and the macro connect to the master side.
interface sram_1024x32_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                  A_VALID;
  logic                  A_READY;
  logic                  A_WE;
  logic [ADDR_W-1:0]     A_ADDR;
  logic [DATA_W-1:0]     A_WDATA;
  logic [DATA_W/8-1:0]   A_BE;
  logic                  A_RVALID;
  logic [DATA_W-1:0]     A_RDATA;

  logic                  B_VALID;
  logic                  B_READY;
  logic                  B_WE;
  logic [ADDR_W-1:0]     B_ADDR;
  logic [DATA_W-1:0]     B_WDATA;
  logic [DATA_W/8-1:0]   B_BE;
  logic                  B_RVALID;
  logic [DATA_W-1:0]     B_RDATA;

  logic [ADDR_W-1:0]     ADDR;
  logic [DATA_W-1:0]     BM;
  logic [DATA_W-1:0]     DIN;
  logic                  WEN;
  logic                  MEN;
  logic                  REN;
  logic [DATA_W-1:0]     DOUT;

  modport slave (
    input  A_VALID, A_WE, A_ADDR, A_WDATA, A_BE,
    input  B_VALID, B_WE, B_ADDR, B_WDATA, B_BE,
    input  DOUT,
    output A_READY, A_RVALID, A_RDATA,
    output B_READY, B_RVALID, B_RDATA,
    output ADDR, BM, DIN, WEN, MEN, REN
  );

  modport master (
    output A_VALID, A_WE, A_ADDR, A_WDATA, A_BE,
    output B_VALID, B_WE, B_ADDR, B_WDATA, B_BE,
    output DOUT,
    input  A_READY, A_RVALID, A_RDATA,
    input  B_READY, B_RVALID, B_RDATA,
    input  ADDR, BM, DIN, WEN, MEN, REN
  );
endinterface

// File: rtl/sram_1024x32_arbiter.sv
// Two-port arbiter and sequencer for the 1024x32 single-port SRAM wrapper.
// It grants one command per cycle, registers the pin stage, and returns read data three cycles after accept.
module sram_1024x32_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  sram_1024x32_arbiter_if.slave   bus
);
  localparam int BE_W = DATA_W / 8;

  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  logic                r_last_b;
  logic                w_a_gnt;
  logic                w_b_gnt;
  logic                w_vld_p0;
  logic                w_we_p0;
  logic [ADDR_W-1:0]   w_addr_p0;
  logic [DATA_W-1:0]   w_wdata_p0;
  logic [BE_W-1:0]     w_be_p0;

  logic                r_men_p1;
  logic                r_wen_p1;
  logic                r_ren_p1;
  logic [ADDR_W-1:0]   r_addr_p1;
  logic [DATA_W-1:0]   r_bm_p1;
  logic [DATA_W-1:0]   r_din_p1;
  logic                r_rd_vld_p1;
  logic                r_port_p1;
  logic                r_rd_vld_p2;
  logic                r_port_p2;

  logic                r_a_rvalid;
  logic                r_b_rvalid;
  logic [DATA_W-1:0]   r_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata;

  // Stage p0: arbitration. On a tie, the port that did not win last time is granted.
  always_comb begin
    w_a_gnt    = !i_rst && bus.A_VALID &&
                 (!bus.B_VALID || (FIXED_PRIO != 0) || r_last_b);
    w_b_gnt    = !i_rst && bus.B_VALID && !w_a_gnt;
    w_vld_p0   = w_a_gnt || w_b_gnt;
    w_we_p0    = w_a_gnt ? bus.A_WE    : bus.B_WE;
    w_addr_p0  = w_a_gnt ? bus.A_ADDR  : bus.B_ADDR;
    w_wdata_p0 = w_a_gnt ? bus.A_WDATA : bus.B_WDATA;
    w_be_p0    = w_a_gnt ? bus.A_BE    : bus.B_BE;
  end

  // Stage p1: SRAM pin registers plus the {read, port} tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_b    <= 1'b1;
      r_men_p1    <= 1'b0;
      r_wen_p1    <= 1'b0;
      r_ren_p1    <= 1'b0;
      r_bm_p1     <= '0;
      r_addr_p1   <= '0;
      r_din_p1    <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_port_p1   <= 1'b0;
    end else begin
      r_men_p1    <= w_vld_p0;
      r_wen_p1    <= w_vld_p0 && w_we_p0;
      r_ren_p1    <= w_vld_p0 && !w_we_p0;
      r_bm_p1     <= (w_vld_p0 && w_we_p0) ? be_to_mask(w_be_p0) : '0;
      r_rd_vld_p1 <= w_vld_p0 && !w_we_p0;
      r_port_p1   <= w_b_gnt;
      if (w_vld_p0) begin
        r_addr_p1 <= w_addr_p0;
        r_din_p1  <= w_we_p0 ? w_wdata_p0 : '0;
        r_last_b  <= w_b_gnt;
      end
    end
  end

  // Stage p2: the tag waits while the macro produces DOUT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_vld_p2 <= 1'b0;
      r_port_p2   <= 1'b0;
    end else begin
      r_rd_vld_p2 <= r_rd_vld_p1;
      r_port_p2   <= r_port_p1;
    end
  end

  // Response stage: DOUT is captured for the port that issued the read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= r_rd_vld_p2 && !r_port_p2;
      r_b_rvalid <= r_rd_vld_p2 && r_port_p2;
      if (r_rd_vld_p2 && !r_port_p2) r_a_rdata <= bus.DOUT;
      if (r_rd_vld_p2 && r_port_p2)  r_b_rdata <= bus.DOUT;
    end
  end

  assign bus.A_READY  = w_a_gnt;
  assign bus.B_READY  = w_b_gnt;
  assign bus.A_RVALID = r_a_rvalid;
  assign bus.B_RVALID = r_b_rvalid;
  assign bus.A_RDATA  = r_a_rdata;
  assign bus.B_RDATA  = r_b_rdata;
  assign bus.ADDR     = r_addr_p1;
  assign bus.BM       = r_bm_p1;
  assign bus.DIN      = r_din_p1;
  assign bus.WEN      = r_wen_p1;
  assign bus.MEN      = r_men_p1;
  assign bus.REN      = r_ren_p1;
endmodule

// File: tb/tb_sram_1024x32_arbiter.sv
// Bench for sram_1024x32_arbiter: directed scenarios followed by random traffic, all checked against a transaction-level model.
// A second instance with FIXED_PRIO=1 shares the same stimulus.
module tb_sram_1024x32_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_1024x32_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();
  sram_1024x32_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus_fp ();

  sram_1024x32_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  sram_1024x32_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(1)) u_dut_fp (
    .i_clk(clk), .i_rst(rst), .bus(bus_fp)
  );

  // Behaviour of the SRAM macro: the command is sampled at the clock edge, and DOUT is valid the following cycle.
  logic [31:0] sram_mem [1024];
  logic [31:0] sram_dout = '0;
  assign bus.DOUT    = sram_dout;
  assign bus_fp.DOUT = '0;
  always @(posedge clk) begin
    if (bus.MEN) begin
      if (bus.WEN) sram_mem[bus.ADDR] = (sram_mem[bus.ADDR] & ~bus.BM) | (bus.DIN & bus.BM);
      if (bus.REN) sram_dout <= sram_mem[bus.ADDR];
    end
  end

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } rsp_t;

  // Reference model state.
  logic [31:0] ref_mem [1024];
  rsp_t        rq[$];
  bit          m_last_b = 1'b1;
  logic        e_men = 0, e_wen = 0, e_ren = 0;
  logic [31:0] e_bm = '0, e_din = '0;
  logic [9:0]  e_addr = '0;
  logic [31:0] e_a_rdata = '0, e_b_rdata = '0;
  bit          acc_a, acc_b;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic we, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bus.A_VALID = v;    bus.A_WE = we;    bus.A_ADDR = addr;    bus.A_WDATA = wd;    bus.A_BE = be;
    bus_fp.A_VALID = v; bus_fp.A_WE = we; bus_fp.A_ADDR = addr; bus_fp.A_WDATA = wd; bus_fp.A_BE = be;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bus.B_VALID = v;    bus.B_WE = we;    bus.B_ADDR = addr;    bus.B_WDATA = wd;    bus.B_BE = be;
    bus_fp.B_VALID = v; bus_fp.B_WE = we; bus_fp.B_ADDR = addr; bus_fp.B_WDATA = wd; bus_fp.B_BE = be;
  endtask

  // One clock cycle. Outputs are checked at the negedge, then the model advances over the posedge.
  task automatic tick();
    logic        ea, eb, we;
    logic [9:0]  addr;
    logic [31:0] wd, bm;
    logic [3:0]  be;
    logic        ev_a, ev_b;
    rsp_t        r;
    @(negedge clk);
    ea = !rst && bus.A_VALID && (!bus.B_VALID || m_last_b);
    eb = !rst && bus.B_VALID && !ea;
    check_eq("a_ready", 32'(bus.A_READY), 32'(ea));
    check_eq("b_ready", 32'(bus.B_READY), 32'(eb));
    check_eq("fp_a_ready", 32'(bus_fp.A_READY), 32'(!rst && bus_fp.A_VALID));
    check_eq("fp_b_ready", 32'(bus_fp.B_READY), 32'(!rst && bus_fp.B_VALID && !bus_fp.A_VALID));
    check_eq("men", 32'(bus.MEN), 32'(e_men));
    check_eq("wen", 32'(bus.WEN), 32'(e_wen));
    check_eq("ren", 32'(bus.REN), 32'(e_ren));
    check_eq("bm", bus.BM, e_bm);
    check_eq("addr", 32'(bus.ADDR), 32'(e_addr));
    check_eq("din", bus.DIN, e_din);
    ev_a = 1'b0;
    ev_b = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.port) begin ev_b = 1'b1; e_b_rdata = r.data; end
      else        begin ev_a = 1'b1; e_a_rdata = r.data; end
    end
    check_eq("a_rvalid", 32'(bus.A_RVALID), 32'(ev_a));
    check_eq("b_rvalid", 32'(bus.B_RVALID), 32'(ev_b));
    check_eq("a_rdata", bus.A_RDATA, e_a_rdata);
    check_eq("b_rdata", bus.B_RDATA, e_b_rdata);

    acc_a = ea;
    acc_b = eb;
    e_men = 1'b0; e_wen = 1'b0; e_ren = 1'b0; e_bm = '0;
    if (ea || eb) begin
      we   = ea ? bus.A_WE    : bus.B_WE;
      addr = ea ? bus.A_ADDR  : bus.B_ADDR;
      wd   = ea ? bus.A_WDATA : bus.B_WDATA;
      be   = ea ? bus.A_BE    : bus.B_BE;
      e_men  = 1'b1;
      e_addr = addr;
      if (we) begin
        bm = '0;
        for (int i = 0; i < 4; i++) if (be[i]) bm = bm | (32'hFF << (8 * i));
        e_wen = 1'b1;
        e_bm  = bm;
        e_din = wd;
        ref_mem[addr] = (ref_mem[addr] & ~bm) | (wd & bm);
      end else begin
        e_ren = 1'b1;
        e_din = '0;
        rq.push_back('{due: cyc + 3, port: eb, data: ref_mem[addr]});
      end
      m_last_b = eb;
    end
    if (rst) begin
      e_men = 0; e_wen = 0; e_ren = 0; e_bm = '0; e_din = '0; e_addr = '0;
      e_a_rdata = '0; e_b_rdata = '0;
      rq.delete();
      m_last_b = 1'b1;
      acc_a = 1'b0;
      acc_b = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit pa, pb;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    set_a(0, 0, '0, '0, '0);
    set_b(0, 0, '0, '0, '0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Write and read back the top word.
    set_a(1, 1, 10'h3FF, 32'hDEADBEEF, 4'hF); tick();
    set_a(1, 0, 10'h3FF, 32'h0, 4'h0);        tick();
    set_a(0, 0, '0, '0, '0);                  idle(4);
    check_eq("top_word_rdata", bus.A_RDATA, 32'hDEADBEEF);

    // Partial write with byte mask.
    set_a(1, 1, 10'd5, 32'h11223344, 4'hF); tick();
    set_a(1, 1, 10'd5, 32'hAABBCCDD, 4'h5); tick();
    set_a(1, 0, 10'd5, 32'h0, 4'h0);        tick();
    set_a(0, 0, '0, '0, '0);                idle(4);
    check_eq("byte_mask_rdata", bus.A_RDATA, 32'h11BB33DD);

    // Write with BE=0 is issued but changes nothing.
    set_a(1, 1, 10'd5, 32'hFFFFFFFF, 4'h0); tick();
    set_a(1, 0, 10'd5, 32'h0, 4'h0);        tick();
    set_a(0, 0, '0, '0, '0);                idle(4);
    check_eq("be_zero_rdata", bus.A_RDATA, 32'h11BB33DD);

    // Round-robin from a fresh reset: both ports request reads for four cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    set_a(1, 0, 10'h3FF, 32'h0, 4'h0);
    set_b(1, 0, 10'd5, 32'h0, 4'h0);
    idle(4);
    set_a(0, 0, '0, '0, '0);
    set_b(0, 0, '0, '0, '0);
    idle(4);

    // Interleaved reads from A and B.
    set_a(1, 1, 10'd1, 32'h1, 4'hF); tick();
    set_a(1, 1, 10'd2, 32'h2, 4'hF); tick();
    set_a(1, 0, 10'd1, 32'h0, 4'h0); tick();
    set_a(0, 0, '0, '0, '0);
    set_b(1, 0, 10'd2, 32'h0, 4'h0); tick();
    set_b(0, 0, '0, '0, '0);         idle(4);
    check_eq("interleave_a_rdata", bus.A_RDATA, 32'h1);
    check_eq("interleave_b_rdata", bus.B_RDATA, 32'h2);

    // Read issued the cycle after a write to the same address.
    set_b(1, 1, 10'd7, 32'hCAFEF00D, 4'hF); tick();
    set_b(1, 0, 10'd7, 32'h0, 4'h0);        tick();
    set_b(0, 0, '0, '0, '0);                idle(4);
    check_eq("raw_rdata", bus.B_RDATA, 32'hCAFEF00D);

    // Reset while a read is in flight.
    set_a(1, 0, 10'd7, 32'h0, 4'h0); tick();
    set_a(0, 0, '0, '0, '0);
    rst = 1'b1; tick(); rst = 1'b0;
    idle(5);
    check_eq("flush_a_rdata", bus.A_RDATA, 32'h0);

    // Random traffic. Each requester holds its command until it is accepted.
    pa = 1'b0;
    pb = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        set_a(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 32'($urandom), 4'($urandom_range(0, 15)));
        pa = 1'b1;
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        set_b(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 32'($urandom), 4'($urandom_range(0, 15)));
        pb = 1'b1;
      end
      tick();
      if (acc_a) begin pa = 1'b0; set_a(0, 0, '0, '0, '0); end
      if (acc_b) begin pb = 1'b0; set_b(0, 0, '0, '0, '0); end
    end
    set_a(0, 0, '0, '0, '0);
    set_b(0, 0, '0, '0, '0);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
